// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch program-counter generator.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } pc_state_t;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam int          DEF_INC          = 4;
  localparam int          DEF_ALIGN_BITS   = 2;

  // A single channel still needs a 1-bit source field.
  function automatic int src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Fixed-priority redirect selector: lowest channel index wins; flags a misaligned winner.
module pc_redirect_arb
  import pc_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int NUM_REDIRECT = 3,
  parameter int ALIGN_BITS   = DEF_ALIGN_BITS
) (
  input  logic [NUM_REDIRECT-1:0]              redirect_valid,
  input  logic [NUM_REDIRECT*XLEN-1:0]         redirect_target,
  output logic                                 sel_valid,
  output logic [src_width(NUM_REDIRECT)-1:0]   sel_idx,
  output logic [XLEN-1:0]                      sel_target,
  output logic                                 sel_misaligned
);

  localparam int SRC_W = src_width(NUM_REDIRECT);
  localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

  // Scan from the top down so the lowest requesting index is written last.
  always_comb begin
    sel_valid  = 1'b0;
    sel_idx    = '0;
    sel_target = '0;
    for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
      if (redirect_valid[i]) begin
        sel_valid  = 1'b1;
        sel_idx    = SRC_W'(i);
        sel_target = redirect_target[i*XLEN +: XLEN];
      end
    end
  end

  assign sel_misaligned = sel_valid && (|(sel_target & ALIGN_MASK));

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register: sequential advance, prioritised redirects, pending redirect while disabled.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter int              INC          = DEF_INC,
  parameter int              NUM_REDIRECT = 3,
  parameter int              ALIGN_BITS   = DEF_ALIGN_BITS
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cpu_en,
  input  logic                               stall,
  input  logic                               fetch_ready,
  input  logic [NUM_REDIRECT-1:0]            redirect_valid,
  input  logic [NUM_REDIRECT*XLEN-1:0]       redirect_target,
  output logic [XLEN-1:0]                    pc,
  output logic                               pc_valid,
  output logic                               redirect_taken,
  output logic [src_width(NUM_REDIRECT)-1:0] redirect_src,
  output logic                               flush,
  output logic                               misalign_err
);

  localparam int SRC_W = src_width(NUM_REDIRECT);

  pc_state_t              state_q, state_d;
  logic [XLEN-1:0]        pc_q, pc_d, pend_target_q, pend_target_d, sel_target;
  logic [SRC_W-1:0]       pend_src_q, pend_src_d, src_q, src_d, sel_idx;
  logic                   pend_valid_q, pend_valid_d, taken_q, taken_d, mis_q, mis_d;
  logic                   sel_valid, sel_misaligned, new_ok, active;

  pc_redirect_arb #(
    .XLEN(XLEN), .NUM_REDIRECT(NUM_REDIRECT), .ALIGN_BITS(ALIGN_BITS)
  ) u_arb (
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .sel_valid      (sel_valid),
    .sel_idx        (sel_idx),
    .sel_target     (sel_target),
    .sel_misaligned (sel_misaligned)
  );

  assign new_ok = sel_valid && !sel_misaligned;
  assign active = cpu_en && (state_q == RUN);

  always_comb begin
    state_d       = state_q;
    pc_valid      = 1'b0;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    pend_src_d    = pend_src_q;
    taken_d       = 1'b0;
    src_d         = src_q;
    mis_d         = sel_valid && sel_misaligned;
    flush         = 1'b0;

    case (state_q)
      BOOT:    if (cpu_en) state_d = RUN;
      RUN: begin
        pc_valid = 1'b1;
        if (!cpu_en) state_d = FROZEN;
      end
      FROZEN:  if (cpu_en) state_d = RUN;
      default: state_d = BOOT;
    endcase

    if (active) begin
      flush = new_ok || pend_valid_q;
      if (new_ok) begin
        pc_d         = sel_target;
        taken_d      = 1'b1;
        src_d        = sel_idx;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        pc_d         = pend_target_q;
        taken_d      = 1'b1;
        src_d        = pend_src_q;
        pend_valid_d = 1'b0;
      end else if (!stall && fetch_ready && !mis_d) begin
        pc_d = pc_q + XLEN'(INC);
      end
    end else if (new_ok) begin
      // PC is frozen: remember the newest aligned redirect for the first enabled RUN edge.
      pend_valid_d  = 1'b1;
      pend_target_d = sel_target;
      pend_src_d    = sel_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      pend_src_q    <= '0;
      taken_q       <= 1'b0;
      src_q         <= '0;
      mis_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      pend_src_q    <= pend_src_d;
      taken_q       <= taken_d;
      src_q         <= src_d;
      mis_q         <= mis_d;
    end
  end

  assign pc             = pc_q;
  assign redirect_taken = taken_q;
  assign redirect_src   = src_q;
  assign misalign_err   = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed plus random stimulus for pc_gen, checked against a behavioural model.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst, cpu_en, stall, fetch_ready;
  logic [2:0]  redirect_valid;
  logic [95:0] redirect_target;
  logic [31:0] pc;
  logic        pc_valid, redirect_taken, flush, misalign_err;
  logic [1:0]  redirect_src;

  int checks = 0;
  int failures = 0;

  // Model: mode 0 = booting, 1 = running, 2 = frozen.
  int          m_mode;
  bit          m_known = 0;
  logic [31:0] m_pc, m_pend_tgt;
  bit          m_pend, m_taken, m_mis;
  int          m_src, m_pend_src;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .stall(stall), .fetch_ready(fetch_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .pc(pc), .pc_valid(pc_valid), .redirect_taken(redirect_taken),
    .redirect_src(redirect_src), .flush(flush), .misalign_err(misalign_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check flush mid-cycle, advance model, check registered outputs.
  task automatic cyc(input bit r, input bit e, input bit s, input bit f, input logic [2:0] v,
                     input logic [31:0] t0, input logic [31:0] t1, input logic [31:0] t2);
    logic [31:0] tg [3];
    int          sel;
    bit          mis, ok, act;
    tg[0] = t0; tg[1] = t1; tg[2] = t2;
    rst = r; cpu_en = e; stall = s; fetch_ready = f;
    redirect_valid = v; redirect_target = {t2, t1, t0};
    sel = -1;
    for (int i = 0; i < 3; i++) if (v[i] && sel < 0) sel = i;
    mis = (sel >= 0) && (tg[sel] % 4 != 0);
    ok  = (sel >= 0) && !mis;
    act = e && (m_mode == 1);
    @(negedge clk);
    if (m_known) chk("flush", {31'd0, flush}, {31'd0, (act && (ok || m_pend))});
    @(posedge clk);
    #1;
    if (r) begin
      m_mode = 0; m_pc = 32'h0; m_pend = 0; m_pend_tgt = 0; m_pend_src = 0;
      m_taken = 0; m_src = 0; m_mis = 0; m_known = 1;
    end else begin
      m_taken = 0;
      m_mis   = mis;
      if (act) begin
        if (ok) begin
          m_pc = tg[sel]; m_taken = 1; m_src = sel; m_pend = 0;
        end else if (m_pend) begin
          m_pc = m_pend_tgt; m_taken = 1; m_src = m_pend_src; m_pend = 0;
        end else if (!s && f && !mis) begin
          m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
        end
      end else if (ok) begin
        m_pend = 1; m_pend_tgt = tg[sel]; m_pend_src = sel;
      end
      m_mode = e ? 1 : ((m_mode == 0) ? 0 : 2);
    end
    chk("pc", pc, m_pc);
    chk("pc_valid", {31'd0, pc_valid}, {31'd0, m_mode == 1});
    chk("redirect_taken", {31'd0, redirect_taken}, {31'd0, m_taken});
    chk("redirect_src", {30'd0, redirect_src}, 32'(m_src));
    chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
  endtask

  initial begin
    rst = 1'b1; cpu_en = 1'b0; stall = 1'b0; fetch_ready = 1'b0;
    redirect_valid = '0; redirect_target = '0;
    @(posedge clk);
    #1;

    // Reset, then free-running fetch.
    cyc(1, 1, 0, 1, 3'b000, 0, 0, 0);
    chk("boot_pc_valid", {31'd0, pc_valid}, 32'd0);
    cyc(0, 1, 0, 1, 3'b000, 0, 0, 0);
    chk("run_pc0", pc, 32'h0);
    cyc(0, 1, 0, 1, 3'b000, 0, 0, 0);
    chk("run_pc4", pc, 32'h4);
    cyc(0, 1, 0, 1, 3'b000, 0, 0, 0);
    cyc(0, 1, 0, 1, 3'b000, 0, 0, 0);
    cyc(0, 1, 0, 1, 3'b000, 0, 0, 0);
    chk("run_pc10", pc, 32'h10);

    // Stall holds pc; a redirect overrides the stall.
    cyc(0, 1, 1, 1, 3'b000, 0, 0, 0);
    chk("stall_hold", pc, 32'h10);
    cyc(0, 1, 1, 1, 3'b010, 0, 32'h200, 0);
    chk("redir_pc", pc, 32'h200);
    chk("redir_src1", {30'd0, redirect_src}, 32'd1);

    // fetch_ready low holds pc.
    cyc(0, 1, 0, 0, 3'b000, 0, 0, 0);
    chk("not_ready_hold", pc, 32'h200);

    // Two channels: lower index wins.
    cyc(0, 1, 0, 1, 3'b110, 0, 32'h100, 32'h300);
    chk("prio_pc", pc, 32'h100);

    // Redirects while disabled are buffered; the newest wins.
    cyc(0, 0, 0, 1, 3'b001, 32'h80, 0, 0);
    cyc(0, 0, 0, 1, 3'b100, 0, 0, 32'h40);
    chk("frozen_hold", pc, 32'h100);
    cyc(0, 1, 0, 1, 3'b000, 0, 0, 0);
    chk("reenable_hold", pc, 32'h100);
    cyc(0, 1, 0, 1, 3'b000, 0, 0, 0);
    chk("pend_applied", pc, 32'h40);
    cyc(0, 1, 0, 1, 3'b000, 0, 0, 0);
    chk("pend_cleared", pc, 32'h44);

    // Misaligned winner blocks the aligned lower-priority channel.
    cyc(0, 1, 0, 1, 3'b011, 32'h102, 32'h200, 0);
    chk("misalign_pulse", {31'd0, misalign_err}, 32'd1);
    chk("misalign_hold", pc, 32'h44);

    // Wrap-around.
    cyc(0, 1, 0, 1, 3'b001, 32'hFFFF_FFFC, 0, 0);
    cyc(0, 1, 0, 1, 3'b000, 0, 0, 0);
    chk("wrap", pc, 32'h0);

    // Reset discards a pending redirect.
    cyc(0, 0, 0, 1, 3'b001, 32'h500, 0, 0);
    cyc(1, 1, 0, 1, 3'b000, 0, 0, 0);
    cyc(0, 1, 0, 1, 3'b000, 0, 0, 0);
    cyc(0, 1, 0, 1, 3'b000, 0, 0, 0);
    chk("pend_discarded", pc, 32'h4);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic [2:0]  v;
      logic [31:0] t [3];
      for (int k = 0; k < 3; k++) begin
        v[k] = ($urandom_range(0, 5) == 0);
        t[k] = $urandom & ~32'h3;
        if ($urandom_range(0, 4) == 0) t[k] = t[k] | 32'($urandom_range(1, 3));
      end
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 5) != 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
          v, t[0], t[1], t[2]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
